// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: per-entry status flags,
// tag-width derivation and the hard-wired zero register index.
package rob_pkg;

  localparam int REG_ZERO = 0;

  // Status bits of one entry; dest and data are width-parameterised and kept
  // in parallel arrays next to this struct.
  typedef struct packed {
    logic valid;
    logic done;
    logic regwrite;
  } rob_entry_t;

  function automatic int tag_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_lookup.sv
// Combinational source lookup: finds the youngest valid entry that will write
// lookup_reg, scanning from head (oldest) so the last match is the youngest.
module rob_lookup
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  localparam int TAG_W = tag_width(DEPTH)
) (
  input  logic [DEPTH-1:0]  entry_valid,
  input  logic [DEPTH-1:0]  entry_done,
  input  logic [DEPTH-1:0]  entry_regwrite,
  input  logic [REG_AW-1:0] entry_dest [DEPTH],
  input  logic [DATA_W-1:0] entry_data [DEPTH],
  input  logic [TAG_W-1:0]  head,
  input  logic [REG_AW-1:0] lookup_reg,
  output logic              lookup_hit,
  output logic              lookup_done,
  output logic [TAG_W-1:0]  lookup_tag,
  output logic [DATA_W-1:0] lookup_data
);

  logic [TAG_W-1:0] idx;

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    lookup_hit  = 1'b0;
    lookup_done = 1'b0;
    lookup_tag  = '0;
    lookup_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + TAG_W'(i);
      if (entry_valid[idx] && entry_regwrite[idx] &&
          entry_dest[idx] == lookup_reg && lookup_reg != REG_AW'(REG_ZERO)) begin
        lookup_hit  = 1'b1;
        lookup_done = entry_done[idx];
        lookup_tag  = idx;
        lookup_data = entry_done[idx] ? entry_data[idx] : '0;
      end
    end
  end

endmodule

// File: rtl/rob_commit_queue.sv
// Reorder buffer: in-order allocate, out-of-order complete by tag, in-order
// retire into the register file, plus a youngest-producer lookup for decode.
module rob_commit_queue
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  localparam int TAG_W = tag_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic              alloc_regwrite,
  input  logic [REG_AW-1:0] alloc_dest,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic [DATA_W-1:0] cmpl_data,
  output logic              commit_valid,
  output logic              commit_regwrite,
  output logic [REG_AW-1:0] commit_dest,
  output logic [DATA_W-1:0] commit_data,
  input  logic [REG_AW-1:0] lookup_reg,
  output logic              lookup_hit,
  output logic              lookup_done,
  output logic [TAG_W-1:0]  lookup_tag,
  output logic [DATA_W-1:0] lookup_data,
  output logic [TAG_W:0]    count
);

  rob_entry_t        entry      [DEPTH];
  logic [REG_AW-1:0] entry_dest [DEPTH];
  logic [DATA_W-1:0] entry_data [DEPTH];
  logic [TAG_W-1:0]  head, tail;
  logic [DEPTH-1:0]  valid_vec, done_vec, regwrite_vec;
  rob_entry_t        head_entry, cmpl_entry;
  logic              do_alloc, do_cmpl;

  assign head_entry = entry[head];
  assign cmpl_entry = entry[cmpl_tag];

  // Fullness is judged on registered occupancy only, never on a same-cycle retire.
  assign alloc_ready = (count != (TAG_W+1)'(DEPTH));
  assign alloc_tag   = tail;
  assign do_alloc    = alloc_valid && alloc_ready && !flush;
  assign do_cmpl     = cmpl_valid && cmpl_entry.valid && !cmpl_entry.done && !flush;

  assign commit_valid    = head_entry.valid && head_entry.done && !flush;
  assign commit_regwrite = commit_valid && head_entry.regwrite &&
                           (entry_dest[head] != REG_AW'(REG_ZERO));
  assign commit_dest     = entry_dest[head];
  assign commit_data     = entry_data[head];

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else begin
      if (do_alloc) begin
        entry[tail] <= '{valid: 1'b1, done: 1'b0, regwrite: alloc_regwrite};
        tail        <= tail + TAG_W'(1);
      end
      if (do_cmpl) entry[cmpl_tag].done <= 1'b1;
      if (commit_valid) begin
        entry[head].valid <= 1'b0;
        head              <= head + TAG_W'(1);
      end
      if (do_alloc && !commit_valid)      count <= count + (TAG_W+1)'(1);
      else if (!do_alloc && commit_valid) count <= count - (TAG_W+1)'(1);
    end
  end

  // NOTE: payload arrays are not reset; the valid flags alone decide whether they are read.
  always_ff @(posedge clk) begin
    if (do_alloc) entry_dest[tail]     <= alloc_dest;
    if (do_cmpl)  entry_data[cmpl_tag] <= cmpl_data;
  end

  always_comb begin
    valid_vec    = '0;
    done_vec     = '0;
    regwrite_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i]    = entry[i].valid;
      done_vec[i]     = entry[i].done;
      regwrite_vec[i] = entry[i].regwrite;
    end
  end

  rob_lookup #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_lookup (
    .entry_valid    (valid_vec),
    .entry_done     (done_vec),
    .entry_regwrite (regwrite_vec),
    .entry_dest     (entry_dest),
    .entry_data     (entry_data),
    .head           (head),
    .lookup_reg     (lookup_reg),
    .lookup_hit     (lookup_hit),
    .lookup_done    (lookup_done),
    .lookup_tag     (lookup_tag),
    .lookup_data    (lookup_data)
  );

endmodule
